// File: rtl/alu16_muldiv_seq.sv
// alu16_muldiv_seq: multi-cycle sequencer that borrows the shared 16-bit ripple ALU
// to perform unsigned 16x16 shift-add multiply and unsigned 16/16 restoring divide.
// One ALU pass per operand bit. A zero divisor bypasses the iteration loop.
module alu16_muldiv_seq #(
    parameter logic [2:0] ALU_OP_ADD = 3'b010,
    parameter int         ITER       = 16
) (
    input  logic        clk,
    input  logic        rst,
    // request side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_div,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    // result side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_hi,
    output logic [15:0] out_lo,
    output logic        out_div0,
    // shared ALU
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cin,
    output logic        alu_ainvert,
    output logic        alu_bnegate,
    output logic        alu_less,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_cout
);

    localparam int CW = $clog2(ITER);

    // DIVZ is the single cycle spent turning a zero-divisor request into its result
    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_DIVZ,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     hi;       // mul: running upper product; div: partial remainder
    logic [15:0]     lo;       // mul: multiplier shifting out; div: dividend in / quotient out
    logic [15:0]     opnd;     // multiplicand or divisor, held for the whole operation
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            div0;
    logic [15:0]     div_s;    // partial remainder shifted left by one, low 16 bits
    logic            div_ok;   // shifted remainder >= divisor: this quotient bit is 1

    assign div_s  = {hi[14:0], lo[15]};
    // A set msb means the 17-bit shifted remainder already exceeds any 16-bit divisor
    assign div_ok = hi[15] | alu_cout;

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign out_hi      = hi;
    assign out_lo      = lo;
    assign out_div0    = div0;
    assign alu_ainvert = 1'b0;
    assign alu_less    = 1'b0;
    assign alu_op      = ALU_OP_ADD;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers update from
        // the same pre-edge values, regardless of statement order.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE: if (in_valid) state_nxt = (in_div && in_b == 16'd0) ? S_DIVZ : S_STEP;
            S_STEP: if (cnt == CW'(ITER - 1)) state_nxt = S_DONE;
            S_DIVZ: state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ALU steering: add for multiply, subtract (b inverted, carry in) for divide
    always_comb begin
        alu_a       = 16'd0;
        alu_b       = 16'd0;
        alu_cin     = 1'b0;
        alu_bnegate = 1'b0;
        if (state == S_STEP) begin
            alu_b = opnd;
            if (is_div) begin
                alu_a       = div_s;
                alu_cin     = 1'b1;
                alu_bnegate = 1'b1;
            end else begin
                alu_a = hi;
            end
        end
    end

    // Datapath: operand capture, one multiply/divide iteration per STEP cycle, div0 result
    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= 16'd0;
            lo     <= 16'd0;
            opnd   <= 16'd0;
            cnt    <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        is_div <= in_div;
                        opnd   <= in_div ? in_b : in_a;
                        hi     <= 16'd0;
                        lo     <= in_div ? in_a : in_b;
                        cnt    <= '0;
                        div0   <= 1'b0;
                    end
                end
                S_STEP: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        hi <= div_ok ? alu_result : div_s;
                        lo <= {lo[14:0], div_ok};
                    end else if (lo[0]) begin
                        {hi, lo} <= {alu_cout, alu_result, lo[15:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[15:1]};
                    end
                end
                S_DIVZ: begin
                    hi   <= lo;          // dividend passed through as remainder
                    lo   <= 16'hFFFF;
                    div0 <= 1'b1;
                end
                S_DONE: ;                // results held until handed off
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_muldiv_seq.sv
// tb_alu16_muldiv_seq: drives directed multiply/divide requests into the sequencer,
// supplies a behavioural ALU, and checks every cycle against an arithmetic model.
module tb_alu16_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_div;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_hi;
    logic [15:0] out_lo;
    logic        out_div0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic        alu_ainvert;
    logic        alu_bnegate;
    logic        alu_less;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_cout;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    alu16_muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_div     (in_div),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hi     (out_hi),
        .out_lo     (out_lo),
        .out_div0   (out_div0),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_ainvert(alu_ainvert),
        .alu_bnegate(alu_bnegate),
        .alu_less   (alu_less),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    // Behavioural ALU: adder with optional b inversion and carry in
    logic [16:0] alu_sum;
    assign alu_sum    = {1'b0, alu_a} + {1'b0, (alu_bnegate ? ~alu_b : alu_b)} + {16'd0, alu_cin};
    assign alu_result = alu_sum[15:0];
    assign alu_cout   = alu_sum[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference for one request
    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        div0;
    } res_t;

    function automatic res_t model(input logic d, input logic [15:0] a, input logic [15:0] b);
        res_t        r;
        logic [31:0] p;
        if (!d) begin
            p      = {16'd0, a} * {16'd0, b};
            r.hi   = p[31:16];
            r.lo   = p[15:0];
            r.div0 = 1'b0;
        end else if (b == 16'd0) begin
            r.hi   = a;
            r.lo   = 16'hFFFF;
            r.div0 = 1'b1;
        end else begin
            r.hi   = a % b;
            r.lo   = a / b;
            r.div0 = 1'b0;
        end
        return r;
    endfunction

    // Transaction-level model: idle / busy for a fixed latency / done until handoff
    typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_left  = 0;
    res_t    m_res   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_state <= M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (in_valid) begin
                    m_state <= M_BUSY;
                    m_res   <= model(in_div, in_a, in_b);
                    m_left  <= (in_div && in_b == 16'd0) ? 1 : 16;
                end
                M_BUSY: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_state <= M_DONE;
                end
                M_DONE: if (out_ready) m_state <= M_IDLE;
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, m_state == M_IDLE});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_state == M_DONE});
            check("alu_op", {29'd0, alu_op}, 32'd2);
            check("alu_ainvert", {31'd0, alu_ainvert}, 32'd0);
            check("alu_less", {31'd0, alu_less}, 32'd0);
            if (m_state != M_BUSY) begin
                check("alu_cin_idle", {31'd0, alu_cin}, 32'd0);
                check("alu_bnegate_idle", {31'd0, alu_bnegate}, 32'd0);
            end
            if (m_state == M_DONE) begin
                check("out_hi", {16'd0, out_hi}, {16'd0, m_res.hi});
                check("out_lo", {16'd0, out_lo}, {16'd0, m_res.lo});
                check("out_div0", {31'd0, out_div0}, {31'd0, m_res.div0});
            end
        end
    end

    // One request with hand-computed expectations; hold = cycles out_ready stays low in DONE
    task automatic run_op(input logic d, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ehi, input logic [15:0] elo, input logic ediv0,
                          input int elat, input int hold, input string tag);
        int lat;
        bit got;
        @(negedge clk);
        in_valid  = 1'b1;
        in_div    = d;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_div   = 1'($urandom);
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_latency"}, lat, elat);
            check({tag, "_hi"}, {16'd0, out_hi}, {16'd0, ehi});
            check({tag, "_lo"}, {16'd0, out_lo}, {16'd0, elo});
            check({tag, "_div0"}, {31'd0, out_div0}, {31'd0, ediv0});
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                in_div   = 1'b0;
                in_a     = 16'd7;
                in_b     = 16'd9;
                check({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                @(negedge clk);
                check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
                check({tag, "_hold_lo"}, {16'd0, out_lo}, {16'd0, elo});
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_back_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_hi"}, {16'd0, out_hi}, 32'd0);
        check({tag, "_out_lo"}, {16'd0, out_lo}, 32'd0);
        check({tag, "_out_div0"}, {31'd0, out_div0}, 32'd0);
        check({tag, "_cin"}, {31'd0, alu_cin}, 32'd0);
        check({tag, "_bnegate"}, {31'd0, alu_bnegate}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_div    = 1'b0;
        in_a      = 16'd0;
        in_b      = 16'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op(1'b0, 16'd3,      16'd5,      16'h0000, 16'h000F, 1'b0, 16, 0, "mul_3x5");
        run_op(1'b0, 16'hFFFF,   16'hFFFF,   16'hFFFE, 16'h0001, 1'b0, 16, 0, "mul_max");
        run_op(1'b1, 16'd100,    16'd7,      16'd2,    16'd14,   1'b0, 16, 0, "div_100_7");
        run_op(1'b1, 16'hFFFF,   16'd1,      16'h0000, 16'hFFFF, 1'b0, 16, 0, "div_max_1");
        run_op(1'b1, 16'd7,      16'd100,    16'd7,    16'd0,    1'b0, 16, 0, "div_small");
        run_op(1'b1, 16'hFFFF,   16'hFFFE,   16'h0001, 16'h0001, 1'b0, 16, 0, "div_msb");
        run_op(1'b1, 16'h8000,   16'd3,      16'd2,    16'h2AAA, 1'b0, 16, 0, "div_8000_3");
        run_op(1'b1, 16'd1234,   16'd0,      16'd1234, 16'hFFFF, 1'b1, 1,  0, "div0");
        run_op(1'b0, 16'd300,    16'd200,    16'h0000, 16'hEA60, 1'b0, 16, 5, "mul_hold");
        run_op(1'b0, 16'd0,      16'hFFFF,   16'h0000, 16'h0000, 1'b0, 16, 0, "mul_zero");

        // Abort a multiply partway through the iterations
        @(negedge clk);
        in_valid = 1'b1;
        in_div   = 1'b0;
        in_a     = 16'd9;
        in_b     = 16'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("abort");
        rst = 1'b0;

        run_op(1'b0, 16'd2, 16'd2, 16'h0000, 16'h0004, 1'b0, 16, 0, "mul_after_abort");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
